// File: rtl/t05_htree_pkg.sv
// Shared definitions for the Huffman tree-builder controller slice.
// Holds the controller state encoding, node-word geometry, the null
// marker used by the sorter and the sum-node liveness test.
`timescale 1ns/1ps
package t05_htree_pkg;

  localparam int NODE_W = 71;
  localparam int IDX_W  = 7;

  // Sorter marker for an exhausted / already-merged slot.
  localparam logic [8:0] NULL_NODE   = 9'h180;
  // Builder enable pattern while a node step is in progress.
  localparam logic [3:0] HT_EN_BUILD = 4'b0011;

  typedef enum logic [3:0] {
    IDLE,
    FIND,
    BUILD,
    WR_TREE,
    WR_NULL1,
    WR_NULL2,
    NEXT,
    DONE,
    ERR
  } state_e;

  // A least-pair entry refers to an earlier sum node (bit 8 set) that must
  // be nulled in SRAM, unless it is the sorter's null marker.
  function automatic logic is_live_sum(input logic [8:0] node);
    return node[8] && (node != NULL_NODE);
  endfunction

endpackage

// File: rtl/t05_sram_port_mux.sv
// Steers either the builder's null-node read or the controller's node
// write onto the single SRAM port. Purely combinational; the controller
// registers the result when it issues the access.
//   rd_sel_i  : 1 = builder read, 0 = controller write
//   rd_addr_i : builder read index
//   wr_addr_i : controller write address
//   wr_data_i : controller write word
//   we_o/addr_o/wdata_o : selected port command
`timescale 1ns/1ps
module t05_sram_port_mux #(
  parameter int NODE_W = 71,
  parameter int IDX_W  = 7
) (
  input  logic              rd_sel_i,
  input  logic [IDX_W-1:0]  rd_addr_i,
  input  logic [IDX_W-1:0]  wr_addr_i,
  input  logic [NODE_W-1:0] wr_data_i,
  output logic              we_o,
  output logic [IDX_W-1:0]  addr_o,
  output logic [NODE_W-1:0] wdata_o
);

  always_comb begin
    we_o    = !rd_sel_i;
    addr_o  = rd_sel_i ? rd_addr_i : wr_addr_i;
    wdata_o = rd_sel_i ? '0 : wr_data_i;
  end

endmodule

// File: rtl/t05_htree_ctrl.sv
// Sequencer and SRAM-port owner for the Huffman tree builder.
// Per iteration: request the least pair from the sorter, enable the builder
// for one node step while serving its null-node reads, then commit the new
// tree node and any nulled sum nodes. Ends on builder completion, a
// node-count overflow or a handshake timeout.
// Ports:
//   start                      : pulse, begin build (honoured in IDLE/DONE/ERR)
//   find_req/find_done/least*  : sorter handshake
//   ht_en/ht_fin/ht_all_done   : builder control and status
//   ht_worr/ht_rd_idx          : builder read request
//   ht_sram_done/ht_nulls      : builder read response
//   tree_node/null1/null2_node : builder results to commit
//   sram_*                     : single SRAM port
//   node_count/done/error      : status
`timescale 1ns/1ps
module t05_htree_ctrl #(
  parameter int NODE_W    = 71,
  parameter int IDX_W     = 7,
  parameter int MAX_NODES = 127,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              find_req,
  input  logic              find_done,
  input  logic [8:0]        least1,
  input  logic [8:0]        least2,
  output logic [3:0]        ht_en,
  input  logic              ht_fin,
  input  logic              ht_all_done,
  input  logic              ht_worr,
  input  logic [IDX_W-1:0]  ht_rd_idx,
  output logic              ht_sram_done,
  output logic [63:0]       ht_nulls,
  input  logic [NODE_W-1:0] tree_node,
  input  logic [NODE_W-1:0] null1_node,
  input  logic [NODE_W-1:0] null2_node,
  output logic              sram_req,
  output logic              sram_we,
  output logic [IDX_W-1:0]  sram_addr,
  output logic [NODE_W-1:0] sram_wdata,
  input  logic [63:0]       sram_rdata,
  input  logic              sram_ack,
  output logic [IDX_W-1:0]  node_count,
  output logic              done,
  output logic              error
);

  import t05_htree_pkg::*;

  localparam int WAIT_W = 8;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [8:0]          l1_q, l2_q;
  logic                rd_block_q;
  logic                find_req_q, done_q, error_q, ht_sram_done_q;
  logic [3:0]          ht_en_q;
  logic [63:0]         ht_nulls_q;
  logic                sram_req_q, sram_we_q;
  logic [IDX_W-1:0]    sram_addr_q, node_count_q;
  logic [NODE_W-1:0]   sram_wdata_q;

  logic                wr_issue, rd_issue, ack_evt, start_go, waiting, en_d, cap;
  logic [IDX_W-1:0]    wr_addr, mux_addr;
  logic [NODE_W-1:0]   wr_data, mux_wdata;
  logic                mux_we;

  t05_sram_port_mux #(
    .NODE_W (NODE_W),
    .IDX_W  (IDX_W)
  ) u_mux (
    .rd_sel_i  (state_q == BUILD),
    .rd_addr_i (ht_rd_idx),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .we_o      (mux_we),
    .addr_o    (mux_addr),
    .wdata_o   (mux_wdata)
  );

  // Write source for the current commit state.
  always_comb begin
    wr_addr = tree_node[NODE_W-1 -: IDX_W];
    wr_data = tree_node;
    case (state_q)
      WR_NULL1: begin
        wr_addr = l1_q[IDX_W-1:0];
        wr_data = null1_node;
      end
      WR_NULL2: begin
        wr_addr = l2_q[IDX_W-1:0];
        wr_data = null2_node;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    wr_issue = 1'b0;
    rd_issue = 1'b0;
    cap      = 1'b0;
    ack_evt  = sram_req_q && sram_ack;
    start_go = 1'b0;
    waiting  = 1'b0;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d  = FIND;
          start_go = 1'b1;
        end
      end
      FIND: begin
        waiting = 1'b1;
        if (find_done) begin
          state_d = BUILD;
          cap     = 1'b1;
        end
      end
      BUILD: begin
        waiting = 1'b1;
        // A builder read in flight must complete before the step can end.
        if (!sram_req_q) begin
          if (ht_all_done)                 state_d  = DONE;
          else if (ht_fin)                 state_d  = WR_TREE;
          else if (ht_worr && !rd_block_q) rd_issue = 1'b1;
        end
      end
      WR_TREE: begin
        waiting = 1'b1;
        if (!sram_req_q) begin
          if (node_count_q == IDX_W'(MAX_NODES)) state_d  = ERR;
          else                                   wr_issue = 1'b1;
        end else if (sram_ack) begin
          if (is_live_sum(l1_q))      state_d = WR_NULL1;
          else if (is_live_sum(l2_q)) state_d = WR_NULL2;
          else                        state_d = NEXT;
        end
      end
      WR_NULL1: begin
        waiting = 1'b1;
        if (!sram_req_q)   wr_issue = 1'b1;
        else if (sram_ack) state_d  = is_live_sum(l2_q) ? WR_NULL2 : NEXT;
      end
      WR_NULL2: begin
        waiting = 1'b1;
        if (!sram_req_q)   wr_issue = 1'b1;
        else if (sram_ack) state_d  = NEXT;
      end
      NEXT:    state_d = FIND;
      default: state_d = IDLE;
    endcase

    if (waiting && !ack_evt && (state_d == state_q) &&
        (wait_q == WAIT_W'(TIMEOUT))) begin
      state_d  = ERR;
      wr_issue = 1'b0;
      rd_issue = 1'b0;
    end

    if ((state_d != state_q) || ack_evt) wait_d = '0;
    else if (waiting && (wait_q != '1))  wait_d = wait_q + 1'b1;
    else                                 wait_d = wait_q;

    // Builder stays enabled from the pair request through the commits so
    // that NEXT is the only low cycle between node steps.
    en_d = (state_d == FIND) || (state_d == BUILD) || (state_d == WR_TREE) ||
           (state_d == WR_NULL1) || (state_d == WR_NULL2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      wait_q         <= '0;
      l1_q           <= '0;
      l2_q           <= '0;
      rd_block_q     <= 1'b0;
      find_req_q     <= 1'b0;
      ht_en_q        <= '0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      ht_sram_done_q <= 1'b0;
      ht_nulls_q     <= '0;
      sram_req_q     <= 1'b0;
      sram_we_q      <= 1'b0;
      sram_addr_q    <= '0;
      sram_wdata_q   <= '0;
      node_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      find_req_q     <= (state_d == FIND);
      ht_en_q        <= en_d ? HT_EN_BUILD : '0;
      done_q         <= (state_d == DONE);
      error_q        <= (state_d == ERR);
      ht_sram_done_q <= ack_evt && !sram_we_q;
      if (ack_evt && !sram_we_q) ht_nulls_q <= sram_rdata;

      if ((state_d == ERR) || ack_evt) begin
        sram_req_q   <= 1'b0;
        sram_we_q    <= 1'b0;
        sram_addr_q  <= '0;
        sram_wdata_q <= '0;
      end else if (wr_issue || rd_issue) begin
        sram_req_q   <= 1'b1;
        sram_we_q    <= mux_we;
        sram_addr_q  <= mux_addr;
        sram_wdata_q <= mux_wdata;
      end

      // One read per ht_worr assertion: rearm only after it drops.
      rd_block_q <= rd_issue || (rd_block_q && ht_worr);

      if (cap) begin
        l1_q <= least1;
        l2_q <= least2;
      end

      if (start_go)                              node_count_q <= '0;
      else if (ack_evt && (state_q == WR_TREE))  node_count_q <= node_count_q + 1'b1;
    end
  end

  assign find_req     = find_req_q;
  assign ht_en        = ht_en_q;
  assign ht_sram_done = ht_sram_done_q;
  assign ht_nulls     = ht_nulls_q;
  assign sram_req     = sram_req_q;
  assign sram_we      = sram_we_q;
  assign sram_addr    = sram_addr_q;
  assign sram_wdata   = sram_wdata_q;
  assign node_count   = node_count_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule
